// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and baud timing helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Narrowest down-counter that can hold a bit period; at least one bit wide.
  function automatic int unsigned timer_width(input int unsigned clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing with configurable data width, mid-bit sampling,
// a single-entry output register with valid/accept handshake, and error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 10_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned DATA_BITS = 7
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       uart_rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       accept_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned TW           = timer_width(CLKS_PER_BIT);

  // Timer counts N-1 down to 0, so a sample lands exactly N cycles after the load.
  localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'((HALF_BIT > 0) ? HALF_BIT - 1 : 0);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  logic        w_rx;
  logic        r_rx_prev;
  logic        w_fall;
  logic        w_tick;

  uart_state_t r_state;
  uart_state_t w_state_next;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;
  logic [2:0]  r_bit_cnt;
  logic [2:0]  w_bit_cnt_next;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_next;
  logic        w_deliver;
  logic        w_frame_err;

  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_frame_err;
  logic        r_overrun;

  uart_sync u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (uart_rx_i),
    .q_o   (w_rx)
  );

  assign w_fall = r_rx_prev & ~w_rx;
  assign w_tick = (r_timer == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_rx_prev <= 1'b1;
      r_timer   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_rx_prev <= w_rx;
      r_timer   <= w_timer_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_shift   <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_timer_next   = r_timer;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
    w_deliver      = 1'b0;
    w_frame_err    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_next = ST_START;
          w_timer_next = HALF_LOAD;
        end
      end

      ST_START: begin
        if (w_tick) begin
          if (!w_rx) begin
            w_state_next   = ST_DATA;
            w_timer_next   = BIT_LOAD;
            w_bit_cnt_next = '0;
            w_shift_next   = '0;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_timer_next = r_timer - TW'(1);
        end
      end

      ST_DATA: begin
        if (w_tick) begin
          w_shift_next[r_bit_cnt] = w_rx;
          w_timer_next            = BIT_LOAD;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_next = ST_STOP;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 3'd1;
          end
        end else begin
          w_timer_next = r_timer - TW'(1);
        end
      end

      ST_STOP: begin
        if (w_tick) begin
          if (w_rx) begin
            w_deliver    = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_state_next = ST_WAIT_HIGH;
          end
        end else begin
          w_timer_next = r_timer - TW'(1);
        end
      end

      ST_WAIT_HIGH: begin
        if (w_rx) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // A same-cycle accept frees the slot, so the new frame loads instead of overrunning.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= 1'b0;
      if (w_deliver) begin
        if (r_valid && !accept_i) begin
          r_overrun <= 1'b1;
        end else begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end
      end else if (r_valid && accept_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of single-frame vectors, directed corner sequences and
// a randomized frame stream checked against a queue-based model of the receiver.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CLK_FREQ  = 330_000;
  localparam int unsigned BAUD      = 10_000;
  localparam int unsigned DATA_BITS = 7;
  localparam int          CPB       = CLK_FREQ / BAUD;
  localparam logic [7:0]  DMASK     = 8'((1 << DATA_BITS) - 1);

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       rx_line = 1'b1;
  logic       accept_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;

  logic acc_en = 1'b0;
  logic force_acc = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  int n_vrise = 0;
  int n_vfall = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_acc = 0;
  logic mon_pv = 1'b0;
  logic [7:0] acc_log [0:1023];

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    int         brk;
    logic [7:0] exp_data;
    int         exp_vld;
    int         exp_ferr;
  } vec_t;

  vec_t vecs [6];

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .DATA_BITS (DATA_BITS)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .uart_rx_i   (rx_line),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .accept_i    (accept_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid_o && !mon_pv) n_vrise++;
    if (!valid_o && mon_pv) n_vfall++;
    if (frame_err_o) n_ferr++;
    if (overrun_o) n_ovr++;
    if (valid_o && accept_i) begin
      acc_log[n_acc % 1024] = data_o;
      n_acc++;
    end
    mon_pv = valid_o;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic waitc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] v, input logic stopv, input int brk, input int gap);
    rx_line = 1'b0;
    waitc(CPB);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx_line = v[i];
      waitc(CPB);
    end
    rx_line = stopv;
    waitc(CPB);
    if (brk > 0) begin
      rx_line = 1'b0;
      waitc(brk * CPB);
    end
    rx_line = 1'b1;
    waitc(gap * CPB);
  endtask

  initial begin
    int b_vr, b_vf, b_fe, b_ov, b_ac;
    int n_early, n_same, n_late;
    logic [7:0] exp_q [$];
    int bad_cnt;

    fork
      forever begin
        @(posedge clk);
        #1;
        accept_i = acc_en ? 1'($urandom_range(0, 1)) : force_acc;
      end
    join_none

    vecs[0] = '{tx: 8'h55, stop: 1'b1, brk: 0, exp_data: 8'h55, exp_vld: 1, exp_ferr: 0};
    vecs[1] = '{tx: 8'hAA, stop: 1'b1, brk: 0, exp_data: 8'h2A, exp_vld: 1, exp_ferr: 0};
    vecs[2] = '{tx: 8'h7F, stop: 1'b1, brk: 0, exp_data: 8'h7F, exp_vld: 1, exp_ferr: 0};
    vecs[3] = '{tx: 8'h00, stop: 1'b1, brk: 0, exp_data: 8'h00, exp_vld: 1, exp_ferr: 0};
    vecs[4] = '{tx: 8'h2A, stop: 1'b0, brk: 3, exp_data: 8'h00, exp_vld: 0, exp_ferr: 1};
    vecs[5] = '{tx: 8'h2B, stop: 1'b1, brk: 0, exp_data: 8'h2B, exp_vld: 1, exp_ferr: 0};

    // Reset state
    waitc(5);
    settle();
    chk("rst_data", data_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_ferr", frame_err_o, 0);
    chk("rst_ovr", overrun_o, 0);
    chk("rst_state", int'(dut.r_state == ST_IDLE), 1);
    @(negedge clk);
    rst_i = 1'b0;
    waitc(2 * CPB);

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      b_vr = n_vrise; b_fe = n_ferr; b_ov = n_ovr; b_ac = n_acc;
      acc_en = 1'b1;
      send_frame(vecs[i].tx, vecs[i].stop, vecs[i].brk, 2);
      settle();
      acc_en = 1'b0;
      chk("row_vrise", n_vrise - b_vr, vecs[i].exp_vld);
      chk("row_ferr", n_ferr - b_fe, vecs[i].exp_ferr);
      chk("row_ovr", n_ovr - b_ov, 0);
      chk("row_nacc", n_acc - b_ac, vecs[i].exp_vld);
      chk("row_valid_end", valid_o, 0);
      if (n_acc > b_ac) chk("row_data", acc_log[b_ac % 1024], vecs[i].exp_data);
    end

    // Back-to-back 0x00..0x1F with two idle bits
    b_ac = n_acc; b_ov = n_ovr;
    acc_en = 1'b1;
    for (int v = 0; v < 32; v++) send_frame(8'(v), 1'b1, 0, 2);
    settle();
    acc_en = 1'b0;
    chk("seq_count", n_acc - b_ac, 32);
    chk("seq_ovr", n_ovr - b_ov, 0);
    for (int v = 0; v < 32; v++) chk("seq_data", acc_log[(b_ac + v) % 1024], v);

    // Overrun: second frame dropped while the first is held
    b_vr = n_vrise; b_ov = n_ovr; b_ac = n_acc;
    send_frame(8'h11, 1'b1, 0, 2);
    send_frame(8'h22, 1'b1, 0, 2);
    settle();
    chk("ovr_pulses", n_ovr - b_ov, 1);
    chk("ovr_vrise", n_vrise - b_vr, 1);
    chk("ovr_data_held", data_o, 8'h11);
    chk("ovr_valid_held", valid_o, 1);
    acc_en = 1'b1;
    waitc(2 * CPB);
    settle();
    acc_en = 1'b0;
    chk("ovr_nacc", n_acc - b_ac, 1);
    chk("ovr_acc_data", acc_log[b_ac % 1024], 8'h11);
    chk("ovr_valid_drop", valid_o, 0);

    // Sweep a one-cycle accept across the delivery point of a second frame
    n_early = 0; n_same = 0; n_late = 0;
    for (int off = 12; off <= 24; off++) begin
      send_frame(8'h11, 1'b1, 0, 2);
      settle();
      b_vf = n_vfall; b_ov = n_ovr; b_ac = n_acc;
      rx_line = 1'b0;
      waitc(CPB);
      for (int i = 0; i < DATA_BITS; i++) begin
        rx_line = 1'(8'h22 >> i);
        waitc(CPB);
      end
      rx_line = 1'b1;
      waitc(off);
      force_acc = 1'b1;
      waitc(1);
      force_acc = 1'b0;
      waitc(CPB - off - 1 + 2 * CPB);
      settle();
      if ((n_acc - b_ac) == 1 && acc_log[b_ac % 1024] == 8'h11) begin
        if (n_ovr == b_ov && valid_o && data_o == 8'h22 && (n_vfall - b_vf) == 1) n_early++;
        else if (n_ovr == b_ov && valid_o && data_o == 8'h22 && n_vfall == b_vf) n_same++;
        else if ((n_ovr - b_ov) == 1 && !valid_o && data_o == 8'h11 && (n_vfall - b_vf) == 1) n_late++;
      end
      chk("sweep_legal", n_early + n_same + n_late, off - 11);
      acc_en = 1'b1;
      waitc(2 * CPB);
      settle();
      acc_en = 1'b0;
    end
    chk("sweep_same_cycle", n_same, 1);
    chk("sweep_early_seen", int'(n_early > 0), 1);
    chk("sweep_late_seen", int'(n_late > 0), 1);

    // Short glitch on the idle line
    b_vr = n_vrise; b_fe = n_ferr; b_ov = n_ovr;
    rx_line = 1'b0;
    waitc(4);
    rx_line = 1'b1;
    waitc(2 * CPB);
    settle();
    chk("glitch_vrise", n_vrise - b_vr, 0);
    chk("glitch_ferr", n_ferr - b_fe, 0);
    chk("glitch_ovr", n_ovr - b_ov, 0);
    chk("glitch_state", int'(dut.r_state == ST_IDLE), 1);

    // Reset during data bit 3 of 0x33 with a held byte pending
    send_frame(8'h66, 1'b1, 0, 2);
    settle();
    chk("pre_rst_valid", valid_o, 1);
    rx_line = 1'b0;
    waitc(CPB);
    for (int i = 0; i < 3; i++) begin
      rx_line = 1'(8'h33 >> i);
      waitc(CPB);
    end
    rx_line = 1'b0;
    waitc(CPB / 2);
    rst_i = 1'b1;
    rx_line = 1'b1;
    waitc(3);
    settle();
    chk("midrst_data", data_o, 0);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_ferr", frame_err_o, 0);
    chk("midrst_ovr", overrun_o, 0);
    chk("midrst_state", int'(dut.r_state == ST_IDLE), 1);
    @(negedge clk);
    rst_i = 1'b0;
    b_vr = n_vrise; b_ac = n_acc;
    waitc(2 * CPB);
    settle();
    chk("postrst_quiet", n_vrise - b_vr, 0);
    acc_en = 1'b1;
    send_frame(8'h44, 1'b1, 0, 2);
    settle();
    acc_en = 1'b0;
    chk("postrst_nacc", n_acc - b_ac, 1);
    chk("postrst_data", acc_log[b_ac % 1024], 8'h44);

    // Randomized frame stream against a queue model
    b_vr = n_vrise; b_fe = n_ferr; b_ov = n_ovr; b_ac = n_acc;
    bad_cnt = 0;
    acc_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [7:0] v;
      logic good;
      v = 8'($urandom);
      good = ($urandom_range(0, 7) != 0);
      if (good) begin
        exp_q.push_back(v & DMASK);
        send_frame(v, 1'b1, 0, $urandom_range(0, 3));
      end else begin
        bad_cnt++;
        send_frame(v, 1'b0, 0, $urandom_range(1, 3));
      end
    end
    waitc(3 * CPB);
    settle();
    acc_en = 1'b0;
    chk("rand_nacc", n_acc - b_ac, exp_q.size());
    chk("rand_vrise", n_vrise - b_vr, exp_q.size());
    chk("rand_ferr", n_ferr - b_fe, bad_cnt);
    chk("rand_ovr", n_ovr - b_ov, 0);
    for (int i = 0; i < exp_q.size(); i++) chk("rand_data", acc_log[(b_ac + i) % 1024], exp_q[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
